// File: rtl/tcp_port_demux_pkg.sv
// Shared definitions for the TCP destination-port demultiplexer: FSM state
// encoding, TCP port width and the socket-select width helper.
package tcp_port_demux_pkg;

  localparam int unsigned TcpPortW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StMatch,
    StHdr,
    StPayload,
    StDrop
  } demux_state_e;

  function automatic int unsigned sel_width(input int unsigned num_sock);
    return (num_sock > 1) ? $clog2(num_sock) : 1;
  endfunction

endpackage

// File: rtl/tcp_port_demux_if.sv
// IP header (valid/ready) plus 8-bit payload AXI-Stream bundle coming out of the
// TCP decapsulation stage.
interface ip_intf;

  logic        ip_hdr_valid;
  logic        ip_hdr_ready;
  logic [31:0] ip_source_ip;
  logic [15:0] ip_length;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport MASTER (
    output ip_hdr_valid, ip_source_ip, ip_length, tdata, tvalid, tlast,
    input  ip_hdr_ready, tready
  );

  modport SLAVE (
    input  ip_hdr_valid, ip_source_ip, ip_length, tdata, tvalid, tlast,
    output ip_hdr_ready, tready
  );

endinterface

// File: rtl/tcp_port_match.sv
// Combinational priority encoder: lowest enabled socket whose listening port
// equals the requested port.
module tcp_port_match
  import tcp_port_demux_pkg::*;
#(
  parameter  int unsigned NUM_SOCK = 4,
  localparam int unsigned SelW     = sel_width(NUM_SOCK)
) (
  input  logic [NUM_SOCK-1:0][TcpPortW-1:0] listen_port_i,
  input  logic [NUM_SOCK-1:0]               listen_en_i,
  input  logic [TcpPortW-1:0]               port_i,
  output logic [SelW-1:0]                   sel_o,
  output logic                              hit_o
);

  // Walk from the top down so the lowest matching index wins.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = int'(NUM_SOCK) - 1; i >= 0; i--) begin
      if (listen_en_i[i] && (listen_port_i[i] == port_i)) begin
        sel_o = SelW'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcp_port_demux.sv
// Routes one IP/TCP packet at a time to the socket listening on its destination
// port; unmatched packets are swallowed and counted.
module tcp_port_demux
  import tcp_port_demux_pkg::*;
#(
  parameter int unsigned NUM_SOCK = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  ip_intf.SLAVE                             s_ip,
  input  logic [TcpPortW-1:0]               i_tcp_dest,
  input  logic                              i_tcp_dest_valid,
  input  logic [NUM_SOCK-1:0][TcpPortW-1:0] i_listen_port,
  input  logic [NUM_SOCK-1:0]               i_listen_en,
  output logic [NUM_SOCK-1:0]               m_hdr_valid,
  input  logic [NUM_SOCK-1:0]               m_hdr_ready,
  output logic [31:0]                       m_hdr_src_ip,
  output logic [15:0]                       m_hdr_length,
  output logic [7:0]                        m_tdata,
  output logic [NUM_SOCK-1:0]               m_tvalid,
  output logic [NUM_SOCK-1:0]               m_tlast,
  input  logic [NUM_SOCK-1:0]               m_tready,
  output logic [15:0]                       o_drop_count
);

  localparam int unsigned SelW = sel_width(NUM_SOCK);

  demux_state_e          state_q, state_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic                  hit_q, hit_d;
  logic [31:0]           src_ip_q, src_ip_d;
  logic [15:0]           len_q, len_d;
  logic [TcpPortW-1:0]   port_q, port_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [SelW-1:0]       match_sel;
  logic                  match_hit;
  logic                  hdr_ready;
  logic                  pay_ready;

  tcp_port_match #(
    .NUM_SOCK (NUM_SOCK)
  ) u_match (
    .listen_port_i (i_listen_port),
    .listen_en_i   (i_listen_en),
    .port_i        (port_q),
    .sel_o         (match_sel),
    .hit_o         (match_hit)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    hit_d       = hit_q;
    src_ip_d    = src_ip_q;
    len_d       = len_q;
    port_d      = port_q;
    drop_cnt_d  = drop_cnt_q;
    hdr_ready   = 1'b0;
    pay_ready   = 1'b0;
    m_hdr_valid = '0;
    m_tvalid    = '0;
    m_tlast     = '0;

    case (state_q)
      StIdle: begin
        // Ready is gated by reset so nothing looks accepted while held in reset.
        hdr_ready = i_rst_n & s_ip.ip_hdr_valid & i_tcp_dest_valid;
        if (s_ip.ip_hdr_valid && i_tcp_dest_valid) begin
          src_ip_d = s_ip.ip_source_ip;
          len_d    = s_ip.ip_length;
          port_d   = i_tcp_dest;
          state_d  = StMatch;
        end
      end
      StMatch: begin
        sel_d   = match_sel;
        hit_d   = match_hit;
        state_d = match_hit ? StHdr : StDrop;
        if (!match_hit && (drop_cnt_q != 16'hFFFF)) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      StHdr: begin
        m_hdr_valid[sel_q] = 1'b1;
        if (m_hdr_ready[sel_q]) begin
          state_d = StPayload;
        end
      end
      StPayload: begin
        m_tvalid[sel_q] = s_ip.tvalid;
        m_tlast[sel_q]  = s_ip.tlast;
        pay_ready       = m_tready[sel_q];
        if (s_ip.tvalid && m_tready[sel_q] && s_ip.tlast) begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        pay_ready = 1'b1;
        if (s_ip.tvalid && s_ip.tlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      hit_q      <= 1'b0;
      src_ip_q   <= '0;
      len_q      <= '0;
      port_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hit_q      <= hit_d;
      src_ip_q   <= src_ip_d;
      len_q      <= len_d;
      port_q     <= port_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign s_ip.ip_hdr_ready = hdr_ready;
  assign s_ip.tready       = pay_ready;
  assign m_hdr_src_ip      = src_ip_q;
  assign m_hdr_length      = len_q;
  assign m_tdata           = s_ip.tdata;
  assign o_drop_count      = drop_cnt_q;

endmodule

// File: tb/tb_tcp_port_demux.sv
// Directed bench for tcp_port_demux: a packet-level scoreboard checks every
// header and beat against the port table, plus hand-computed literals.
module tb_tcp_port_demux;

  localparam int NS = 4;

  typedef struct {
    int          sock;
    logic [31:0] src;
    logic [15:0] len;
    int          n;
    logic [7:0]  base;
  } pkt_t;

  logic                  clk;
  logic                  rst_n;
  logic [15:0]           tcp_dest;
  logic                  dest_valid;
  logic [NS-1:0][15:0]   listen_port;
  logic [NS-1:0]         listen_en;
  logic [NS-1:0]         m_hdr_valid;
  logic [NS-1:0]         m_hdr_ready;
  logic [31:0]           m_hdr_src_ip;
  logic [15:0]           m_hdr_length;
  logic [7:0]            m_tdata;
  logic [NS-1:0]         m_tvalid;
  logic [NS-1:0]         m_tlast;
  logic [NS-1:0]         m_tready;
  logic [15:0]           drop_count;
  logic                  toggle_en;

  int n_checks = 0;
  int n_fail   = 0;

  pkt_t exp_arr[64];
  int   n_pushed = 0;

  // Monitor-owned state.
  pkt_t p;
  int   cyc, cur, beat_idx, hs_cyc, first_cyc, span, done_cyc, drops_done;
  bit   hdr_open, hdr_seen, have;
  int   beats_sock[NS];
  int   hdr_cnt[NS];

  ip_intf ip_if ();

  tcp_port_demux #(
    .NUM_SOCK (NS)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .s_ip             (ip_if),
    .i_tcp_dest       (tcp_dest),
    .i_tcp_dest_valid (dest_valid),
    .i_listen_port    (listen_port),
    .i_listen_en      (listen_en),
    .m_hdr_valid      (m_hdr_valid),
    .m_hdr_ready      (m_hdr_ready),
    .m_hdr_src_ip     (m_hdr_src_ip),
    .m_hdr_length     (m_hdr_length),
    .m_tdata          (m_tdata),
    .m_tvalid         (m_tvalid),
    .m_tlast          (m_tlast),
    .m_tready         (m_tready),
    .o_drop_count     (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Lowest enabled socket listening on the port, or -1 when nobody listens.
  function automatic int route(input logic [15:0] dest);
    for (int i = 0; i < NS; i++) begin
      if (listen_en[i] && listen_port[i] == dest) return i;
    end
    return -1;
  endfunction

  task automatic send_hdr(input logic [31:0] src, input logic [15:0] len,
                          input logic [15:0] dest, input int n, input logic [7:0] base);
    int k;
    exp_arr[n_pushed] = '{sock: route(dest), src: src, len: len, n: n, base: base};
    n_pushed++;
    ip_if.ip_hdr_valid = 1'b1;
    ip_if.ip_source_ip = src;
    ip_if.ip_length    = len;
    tcp_dest           = dest;
    dest_valid         = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ip_if.ip_hdr_ready && k < 100);
    chk("hdr_accepted", int'(ip_if.ip_hdr_ready), 1);
    @(posedge clk);
    #1;
    ip_if.ip_hdr_valid = 1'b0;
    dest_valid         = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int k;
    ip_if.tvalid = 1'b1;
    ip_if.tdata  = d;
    ip_if.tlast  = last;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ip_if.tready && k < 100);
    chk("beat_accepted", int'(ip_if.tready), 1);
    @(posedge clk);
    #1;
    ip_if.tvalid = 1'b0;
    ip_if.tlast  = 1'b0;
  endtask

  task automatic send_pay(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) send_beat(base + 8'(k), k == n - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sink back-pressure: all ready, or socket 1 alternating every cycle.
  initial begin
    m_tready = '1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) m_tready[1] = ~m_tready[1];
      else m_tready = '1;
    end
  end

  // Scoreboard: checks every cycle against the packet expected at the head.
  initial begin
    logic [7:0] eb;
    cyc = 0; cur = 0; beat_idx = 0; hs_cyc = 0; first_cyc = 0; span = 0;
    done_cyc = 0; drops_done = 0; hdr_open = 0; hdr_seen = 0; have = 0;
    for (int s = 0; s < NS; s++) begin
      beats_sock[s] = 0;
      hdr_cnt[s]    = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        cur = n_pushed; beat_idx = 0; hdr_open = 0; hdr_seen = 0; drops_done = 0;
      end else begin
        if (ip_if.ip_hdr_ready) begin
          chk("hdr_ready_while_busy", int'(hdr_open), 0);
          hdr_open = 1; hdr_seen = 0; hs_cyc = cyc; beat_idx = 0;
        end
        have = hdr_open && (cur < n_pushed);
        if (have) p = exp_arr[cur];
        if (have && p.sock >= 0 && hdr_seen && ip_if.tvalid)
          chk("tready_passthru", int'(ip_if.tready), int'(m_tready[p.sock]));
        for (int s = 0; s < NS; s++) begin
          if (m_tvalid[s]) chk("tvalid_sock", s, have ? p.sock : -1);
          if (m_tvalid[s] && m_tready[s]) beats_sock[s]++;
        end
        if (ip_if.tvalid && ip_if.tready) begin
          if (!have) begin
            chk("beat_without_pkt", int'(ip_if.tready), 0);
          end else begin
            if (beat_idx == 0) begin
              chk("hdr_to_data_latency_ge2", int'((cyc - hs_cyc) >= 2), 1);
              first_cyc = cyc;
              if (p.sock >= 0) chk("hdr_before_data", int'(hdr_seen), 1);
            end
            if (p.sock >= 0) begin
              eb = p.base + 8'(beat_idx);
              chk("data_tvalid", int'(m_tvalid[p.sock]), 1);
              chk("data_byte", int'(m_tdata), int'(eb));
              chk("data_tlast", int'(m_tlast[p.sock]), int'(beat_idx == p.n - 1));
            end else begin
              chk("drop_no_tvalid", int'(m_tvalid), 0);
            end
            beat_idx++;
            if (ip_if.tlast) begin
              chk("beat_count", beat_idx, p.n);
              span = cyc - first_cyc;
              done_cyc = cyc;
              if (p.sock < 0) drops_done++;
              chk("drop_count", int'(drop_count), drops_done);
              cur++; beat_idx = 0; hdr_open = 0;
            end
          end
        end
        have = hdr_open && (cur < n_pushed);
        for (int s = 0; s < NS; s++) begin
          if (m_hdr_valid[s]) begin
            chk("hdr_sock", s, have ? exp_arr[cur].sock : -1);
            if (have) begin
              chk("hdr_src_ip", int'(m_hdr_src_ip), int'(exp_arr[cur].src));
              chk("hdr_length", int'(m_hdr_length), int'(exp_arr[cur].len));
            end
            if (m_hdr_ready[s]) begin
              hdr_cnt[s]++;
              hdr_seen = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    toggle_en          = 1'b0;
    m_hdr_ready        = '1;
    listen_port[0]     = 16'd80;
    listen_port[1]     = 16'd23;
    listen_port[2]     = 16'd80;
    listen_port[3]     = 16'h1F90;
    listen_en          = '1;
    tcp_dest           = '0;
    ip_if.ip_source_ip = '0;
    ip_if.ip_length    = '0;
    ip_if.tdata        = '0;
    // Drive everything active during reset: nothing may be accepted or emitted.
    ip_if.ip_hdr_valid = 1'b1;
    dest_valid         = 1'b1;
    ip_if.tvalid       = 1'b1;
    ip_if.tlast        = 1'b1;
    rst_n              = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hdr_ready", int'(ip_if.ip_hdr_ready), 0);
    chk("rst_tready", int'(ip_if.tready), 0);
    chk("rst_hdr_valid", int'(m_hdr_valid), 0);
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_tlast", int'(m_tlast), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    ip_if.ip_hdr_valid = 1'b0;
    dest_valid         = 1'b0;
    ip_if.tvalid       = 1'b0;
    ip_if.tlast        = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Port 80, five bytes: socket 0 only.
    send_hdr(32'h0A000001, 16'd45, 16'd80, 5, 8'h10);
    chk("model_route_80", exp_arr[n_pushed-1].sock, 0);
    send_pay(5, 8'h10);
    idle(2);
    chk("t1_beats_s0", beats_sock[0], 5);
    chk("t1_hdr_s0", hdr_cnt[0], 1);
    chk("t1_beats_s2", beats_sock[2], 0);
    chk("t1_hdr_s2", hdr_cnt[2], 0);

    // Unmatched port: swallowed, counted once.
    send_hdr(32'h0A000002, 16'd50, 16'h1234, 10, 8'h40);
    chk("model_route_none", exp_arr[n_pushed-1].sock, -1);
    send_pay(10, 8'h40);
    idle(2);
    chk("t2_drop_count", int'(drop_count), 1);
    chk("t2_beats_s0", beats_sock[0], 5);

    // Port 23 with socket 1 ready toggling: one beat every two cycles.
    toggle_en = 1'b1;
    send_hdr(32'hC0A80001, 16'd46, 16'd23, 6, 8'h60);
    send_pay(6, 8'h60);
    toggle_en = 1'b0;
    chk("t3_span", span, 10);
    idle(2);
    chk("t3_beats_s1", beats_sock[1], 6);

    // Second header offered while the first payload is still flowing.
    fork
      begin
        send_hdr(32'h0A000003, 16'd44, 16'd80, 4, 8'h80);
        send_pay(4, 8'h80);
      end
      begin
        idle(4);
        send_hdr(32'h0A000004, 16'd43, 16'h1F90, 3, 8'hA0);
        chk("t4_hdr2_after_tlast", int'(hs_cyc > done_cyc), 1);
      end
    join
    send_pay(3, 8'hA0);
    idle(2);
    chk("t4_hdr_s3", hdr_cnt[3], 1);
    chk("t4_beats_s3", beats_sock[3], 3);

    // Socket 0 disabled mid-packet: current packet stays, next goes to socket 2.
    fork
      begin
        send_hdr(32'h0A000005, 16'd46, 16'd80, 6, 8'hC0);
        send_pay(6, 8'hC0);
      end
      begin
        idle(4);
        listen_en[0] = 1'b0;
      end
    join
    send_hdr(32'h0A000006, 16'd42, 16'd80, 2, 8'hD0);
    chk("model_route_80_s2", exp_arr[n_pushed-1].sock, 2);
    send_pay(2, 8'hD0);
    idle(2);
    chk("t5_beats_s0", beats_sock[0], 15);
    chk("t5_hdr_s0", hdr_cnt[0], 3);
    chk("t5_beats_s2", beats_sock[2], 2);
    chk("t5_hdr_s2", hdr_cnt[2], 1);

    // Reset pulsed mid-payload.
    send_hdr(32'h0A000007, 16'd45, 16'd23, 5, 8'hE0);
    send_beat(8'hE0, 1'b0);
    send_beat(8'hE1, 1'b0);
    ip_if.tvalid       = 1'b1;
    ip_if.tdata        = 8'hE2;
    ip_if.ip_hdr_valid = 1'b1;
    dest_valid         = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_tvalid", int'(m_tvalid), 0);
    chk("t6_tlast", int'(m_tlast), 0);
    chk("t6_hdr_valid", int'(m_hdr_valid), 0);
    chk("t6_tready", int'(ip_if.tready), 0);
    chk("t6_hdr_ready", int'(ip_if.ip_hdr_ready), 0);
    chk("t6_drop_count", int'(drop_count), 0);
    @(posedge clk);
    #1;
    ip_if.ip_hdr_valid = 1'b0;
    dest_valid         = 1'b0;
    rst_n              = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_resync", int'(ip_if.tready), 0);
    end
    @(posedge clk);
    #1;
    ip_if.tvalid = 1'b0;
    idle(1);
    send_hdr(32'h0A000008, 16'd43, 16'd23, 3, 8'hF0);
    send_pay(3, 8'hF0);
    idle(2);
    chk("t7_beats_s1", beats_sock[1], 11);
    chk("t7_hdr_s1", hdr_cnt[1], 3);
    chk("t7_drop_count", int'(drop_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tcp_port_demux.md
TCP_PORT_DEMUX -- requirements
Module: tcp_port_demux

Interface
REQ-001 Parameter NUM_SOCK, default 4, number of socket outputs (1..8).
REQ-002 i_clk  input  1  single clock; all logic on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_ip  ip_intf.SLAVE  --  IP header (valid/ready) plus 8-bit payload AXIS from the TCP destination-port decapsulation stage; MAC/ethertype fields ignored.
REQ-005 i_tcp_dest  input  16  TCP destination port of the packet currently on s_ip.
REQ-006 i_tcp_dest_valid  input  1  i_tcp_dest is valid.
REQ-007 i_listen_port  input  NUM_SOCK x 16  listening port per socket.
REQ-008 i_listen_en  input  NUM_SOCK  per-socket enable.
REQ-009 m_hdr_valid / m_hdr_ready  output / input  NUM_SOCK each  per-socket header handshake.
REQ-010 m_hdr_src_ip  output  32  source IP of the packet; m_hdr_length  output  16  ip_length; shared by all sockets.
REQ-011 m_tdata  output  8; m_tvalid, m_tlast  output  NUM_SOCK each; m_tready  input  NUM_SOCK  per-socket payload AXIS (tdata shared).
REQ-012 o_drop_count  output  16  packets dropped for no matching port.

Function
REQ-013 FSM states: IDLE, MATCH, HDR, PAYLOAD, DROP.
REQ-014 IDLE: s_ip.ip_hdr_ready = 1 only when s_ip.ip_hdr_valid and i_tcp_dest_valid are both 1; on that handshake latch ip_source_ip, ip_length and i_tcp_dest, then go to MATCH.
REQ-015 MATCH (exactly 1 cycle): register sel = lowest index i with i_listen_en[i]=1 and i_listen_port[i]==latched port, plus a hit flag; on hit go to HDR, otherwise go to DROP.
REQ-016 Header-to-first-payload latency: at least 2 cycles after the header handshake (MATCH, then HDR).
REQ-017 HDR: m_hdr_valid[sel]=1 and all other m_hdr_valid bits 0; fields stay stable until m_hdr_ready[sel]; on that handshake go to PAYLOAD.
REQ-018 PAYLOAD: combinational pass-through, no bubbles; m_tvalid[sel]=s_ip tvalid, m_tlast[sel]=s_ip tlast, m_tdata=s_ip tdata, s_ip tready=m_tready[sel]; non-selected m_tvalid/m_tlast bits = 0.
REQ-019 PAYLOAD exit: on a beat with tvalid & tready & tlast, go to IDLE.
REQ-020 DROP: s_ip tready=1 and all m_tvalid bits = 0; on a beat with tvalid & tlast, go to IDLE.
REQ-021 Drop counter: o_drop_count increments by 1 on the MATCH->DROP transition and saturates at 16'hFFFF.
REQ-022 Stable selection: sel and the latched port are held from MATCH until the return to IDLE; i_listen_port/i_listen_en changes mid-packet do not affect the current packet.
REQ-023 Overlapping headers: s_ip.ip_hdr_ready = 0 in every state except IDLE, so the next header waits until the current payload's tlast.
REQ-024 Zero-length payload: not supported; every packet carries at least one tlast beat.
REQ-025 Back-pressure: a stalled m_tready[sel] stalls only the input; no data is buffered inside the block.

Reset
REQ-026 While i_rst_n=0: state=IDLE; sel, hit and latched fields = 0; o_drop_count=0.
REQ-027 While i_rst_n=0: all m_hdr_valid, m_tvalid and m_tlast = 0; s_ip ready outputs = 0.
REQ-028 Reset asserted mid-packet abandons the packet; after release the block waits in IDLE for a new header and does not resynchronise to the remaining payload.

Structure
REQ-029 A shared network package holds the FSM state enum and the TCP port width constant (16).
REQ-030 The port-match priority encoder is a sub-module named tcp_port_match; it is combinational, and the match result is registered in MATCH.

Verification
REQ-031 Listen ports {80,23,80,0x1F90} all enabled; packet with dest 80, 5 bytes -> socket 0 only gets header and 5 beats, last on byte 5; socket 2 idle.
REQ-032 Dest 0x1234 with no match, 10 bytes -> s_ip tready=1 for all beats, no m_tvalid, o_drop_count 0->1.
REQ-033 Dest 23, m_tready[1] toggled 1-0-1 each cycle -> byte sequence intact, throughput 50%, no duplicated or lost beats.
REQ-034 Second header presented during the first packet's payload -> ip_hdr_ready stays 0 until after the first tlast; second packet routed correctly.
REQ-035 i_listen_en[0] cleared mid-packet to port 80 -> current packet completes on socket 0; next port-80 packet goes to socket 2.
REQ-036 i_rst_n pulsed low mid-payload -> outputs 0 immediately, drop count 0, next full packet routed normally.
